// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: shared pixel tick plus h/v counters, syncs, video qualifier and frame marker.
// Optional frame counter port enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing_controller #(
  parameter int DIV_VALUE = 1,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV_VALUE > 0) ? $clog2(DIV_VALUE + 1) : 1;

  localparam logic [DW-1:0] DIV_MAX   = DW'(DIV_VALUE);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]    H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]    V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [9:0]    h_cnt, v_cnt;
  logic          fs_q;
  logic          run, tick, h_wrap, v_wrap;

  assign run    = (state == RUN);
  assign tick   = run && (div_cnt == DIV_MAX);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      fs_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          h_cnt   <= '0;
          v_cnt   <= '0;
          fs_q    <= en;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            // dropping en mid-frame abandons the raster; restart is always at (0,0)
            state   <= IDLE;
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            fs_q    <= 1'b0;
          end else begin
            fs_q    <= 1'b0;
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DW'(1);
            if (tick) begin
              if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                  v_cnt <= '0;
                  fs_q  <= 1'b1;
                end else begin
                  v_cnt <= v_cnt + 10'd1;
                end
              end else begin
                h_cnt <= h_cnt + 10'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_count <= '0;
    else if (en && tick && h_wrap && v_wrap)
      frame_count <= frame_count + 8'd1;
  end
`endif

  // every output is decoded from the same registers, so all change on one edge
  assign pixel_tick  = tick;
  assign hsync       = !(run && h_cnt >= H_SYNC_LO && h_cnt <= H_SYNC_HI);
  assign vsync       = !(run && v_cnt >= V_SYNC_LO && v_cnt <= V_SYNC_HI);
  assign video_on    = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: default-timing line scan table, small-raster frame scan, optional frame counter.
module tb_vga_timing_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       a_tick, a_hs, a_vs, a_von, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_von, b_fs;
  logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] fc_a, fc_b, fc_c;
  logic       en_c = 1'b0;
  logic       c_tick, c_hs, c_vs, c_von, c_fs;
  logic [9:0] c_x, c_y;
`endif

  vga_timing_controller u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_von), .pixel_x(a_x), .pixel_y(a_y), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(fc_a)
`endif
  );

  vga_timing_controller #(
    .DIV_VALUE(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(fc_b)
`endif
  );

`ifdef VGA_FRAME_COUNTER_EN
  vga_timing_controller #(
    .DIV_VALUE(0), .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .pixel_tick(c_tick), .hsync(c_hs), .vsync(c_vs),
    .video_on(c_von), .pixel_x(c_x), .pixel_y(c_y), .frame_start(c_fs), .frame_count(fc_c)
  );
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic tk, input logic hs, input logic vs,
                       input logic von, input int x, input int y, input logic fs);
    chk({nm, ".tick"}, a_tick, tk);
    chk({nm, ".hsync"}, a_hs, hs);
    chk({nm, ".vsync"}, a_vs, vs);
    chk({nm, ".video_on"}, a_von, von);
    chk({nm, ".x"}, a_x, x);
    chk({nm, ".y"}, a_y, y);
    chk({nm, ".frame_start"}, a_fs, fs);
  endtask

  typedef struct {
    logic en; int adv;
    logic tick, hs, vs, von; int x, y; logic fs;
  } vec_t;
  vec_t vt[19];

  initial begin
    int nfs, fs2, nhs, nvs, nvon, hs_first, vs_first;

    // default timing: one pixel per 2 clk; cycle c counts from the first RUN cycle
    vt[0]  = '{1'b1, 1,    1'b0, 1'b1, 1'b1, 1'b1, 0,   0, 1'b1}; // c=0 first RUN cycle
    vt[1]  = '{1'b1, 1,    1'b1, 1'b1, 1'b1, 1'b1, 0,   0, 1'b0}; // c=1 tick
    vt[2]  = '{1'b1, 1,    1'b0, 1'b1, 1'b1, 1'b1, 1,   0, 1'b0}; // c=2
    vt[3]  = '{1'b1, 1276, 1'b0, 1'b1, 1'b1, 1'b1, 639, 0, 1'b0}; // last active pixel
    vt[4]  = '{1'b1, 2,    1'b0, 1'b1, 1'b1, 1'b0, 640, 0, 1'b0}; // front porch
    vt[5]  = '{1'b1, 30,   1'b0, 1'b1, 1'b1, 1'b0, 655, 0, 1'b0};
    vt[6]  = '{1'b1, 2,    1'b0, 1'b0, 1'b1, 1'b0, 656, 0, 1'b0}; // hsync asserts
    vt[7]  = '{1'b1, 1,    1'b1, 1'b0, 1'b1, 1'b0, 656, 0, 1'b0};
    vt[8]  = '{1'b1, 189,  1'b0, 1'b0, 1'b1, 1'b0, 751, 0, 1'b0}; // last sync pixel
    vt[9]  = '{1'b1, 2,    1'b0, 1'b1, 1'b1, 1'b0, 752, 0, 1'b0};
    vt[10] = '{1'b1, 94,   1'b0, 1'b1, 1'b1, 1'b0, 799, 0, 1'b0};
    vt[11] = '{1'b1, 1,    1'b1, 1'b1, 1'b1, 1'b0, 799, 0, 1'b0};
    vt[12] = '{1'b1, 1,    1'b0, 1'b1, 1'b1, 1'b1, 0,   1, 1'b0}; // line wrap
    vt[13] = '{1'b1, 600,  1'b0, 1'b1, 1'b1, 1'b1, 300, 1, 1'b0};
    vt[14] = '{1'b0, 1,    1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0}; // en dropped
    vt[15] = '{1'b0, 9,    1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0};
    vt[16] = '{1'b1, 1,    1'b0, 1'b1, 1'b1, 1'b1, 0,   0, 1'b1}; // restart
    vt[17] = '{1'b1, 1,    1'b1, 1'b1, 1'b1, 1'b1, 0,   0, 1'b0};
    vt[18] = '{1'b1, 1,    1'b0, 1'b1, 1'b1, 1'b1, 1,   0, 1'b0};

    repeat (2) @(negedge clk);
    chk_a("rst", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
`ifdef VGA_FRAME_COUNTER_EN
    chk("rst.frame_count", fc_a, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk_a("idle", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      en_a = vt[i].en;
      repeat (vt[i].adv) @(negedge clk);
      chk_a($sformatf("vec%0d", i), vt[i].tick, vt[i].hs, vt[i].vs, vt[i].von,
            vt[i].x, vt[i].y, vt[i].fs);
    end

    // async reset asserted between edges takes effect immediately
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst.x", a_x, 0);
    chk("async_rst.video_on", a_von, 0);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // small raster: 15 px x 8 lines, 2 clk per pixel -> 240 clk frame
    nfs = 0; fs2 = -1; nhs = 0; nvs = 0; nvon = 0; hs_first = -1; vs_first = -1;
    en_b = 1'b1;
    for (int c = 0; c < 480; c++) begin
      @(negedge clk);
      if (b_fs) begin nfs++; if (c > 0) fs2 = c; end
      if (!b_hs) begin nhs++; if (hs_first < 0) hs_first = c; end
      if (!b_vs) begin nvs++; if (vs_first < 0) vs_first = c; end
      if (b_von) nvon++;
      if (c == 239) begin
        chk("b.last.x", b_x, 14);
        chk("b.last.y", b_y, 7);
        chk("b.last.tick", b_tick, 1);
      end
      if (c == 240) begin
        chk("b.wrap.x", b_x, 0);
        chk("b.wrap.y", b_y, 0);
      end
    end
    chk("b.fs_count", nfs, 2);
    chk("b.frame_period", fs2, 240);
    chk("b.hs_low_clk", nhs, 96);
    chk("b.vs_low_clk", nvs, 120);
    chk("b.video_on_clk", nvon, 128);
    chk("b.hs_first", hs_first, 20);
    chk("b.vs_first", vs_first, 150);
    en_b = 1'b0;
    @(negedge clk);

`ifdef VGA_FRAME_COUNTER_EN
    // 4x4 raster, tick every clk -> 16 clk frame
    en_c = 1'b1;
    @(negedge clk);
    chk("c.fc0", fc_c, 0);
    for (int k = 1; k <= 259; k++) begin
      repeat (16) @(negedge clk);
      chk($sformatf("c.fc%0d", k), fc_c, k % 256);
    end
    repeat (5) @(negedge clk);
    en_c = 1'b0;
    repeat (8) @(negedge clk);
    chk("c.hold.fc", fc_c, 3);
    chk("c.hold.x", c_x, 0);
    en_c = 1'b1;
    @(negedge clk);
    chk("c.restart.fc", fc_c, 3);
    chk("c.restart.fs", c_fs, 1);
    repeat (16) @(negedge clk);
    chk("c.after.fc", fc_c, 4);
    en_c = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Sequences the VGA raster: derives a pixel-rate tick from the 50 MHz system clock and steps horizontal/vertical counters through active, front-porch, sync and back-porch phases. Produces hsync/vsync, a video-active qualifier and pixel coordinates for the pixel generator. Sits between the system clock and the pixel/colour logic and replaces per-block free-running dividers with one tick shared by all raster logic.

## Interface
- DIV_VALUE, 1: pixel tick every DIV_VALUE+1 clk cycles (1 → 25 MHz from 50 MHz)
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal phase lengths in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical phase lengths in lines
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  run raster when high; idle when low
- pixel_tick  output  1  one-clk pulse; counters advance on the edge where it is high
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video_on  output  1  high when (pixel_x, pixel_y) is in the active area
- pixel_x  output  10  horizontal count, 0..H_TOTAL-1
- pixel_y  output  10  vertical count, 0..V_TOTAL-1
- frame_start  output  1  one-clk pulse marking pixel (0,0)
- frame_count  output  8  frames completed (only with VGA_FRAME_COUNTER_EN)

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525); both ≤ 1024; every phase length ≥ 1.
- State: IDLE, RUN. Reset → IDLE. IDLE→RUN on an edge sampling en=1; RUN→IDLE on an edge sampling en=0 (any point, mid-line or mid-frame).
- IDLE: div_cnt, h_cnt, v_cnt held at 0; pixel_tick=0, hsync=1, vsync=1, video_on=0, frame_start=0.
- RUN: div_cnt counts 0..DIV_VALUE, wraps to 0. pixel_tick = (div_cnt == DIV_VALUE).
- On tick: h_cnt++; at H_TOTAL-1 wraps to 0 and v_cnt++; v_cnt at V_TOTAL-1 with h wrap → 0.
- Horizontal phase: ACTIVE h<H_ACTIVE; FP next H_FP; SYNC next H_SYNC; BP remainder. Vertical identical on v_cnt.
- hsync=0 iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync likewise on v_cnt.
- video_on = RUN && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- pixel_x=h_cnt, pixel_y=v_cnt in all states.
- frame_start = 1 for the first clk in RUN after IDLE, and for the clk after the tick edge that wraps to (0,0).
- All outputs decoded only from registered state; no combinational en→output path.

## Timing
- Reset (async assert): all counters 0, state IDLE, outputs at IDLE values immediately; deassert synchronous to clk.
- en sampled high at edge N: RUN from N; video_on=1, frame_start=1 in cycle N..N+1; first pixel_tick DIV_VALUE+1 cycles later; (0,0) held DIV_VALUE+1 cycles.
- Each coordinate held exactly DIV_VALUE+1 clk cycles; line = H_TOTAL*(DIV_VALUE+1) clk; frame = V_TOTAL lines.
- en dropped at edge M: IDLE values from M; re-enable restarts at (0,0) with div_cnt=0.
- Sync, video_on, coordinates change on the same edge (coherent, zero relative skew).

## Configuration
- VGA_FRAME_COUNTER_EN defined: frame_count port present; reset 0; increments by 1 on each wrap to (0,0) in RUN, wraps 255→0; held (not cleared) in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset with en=0 → pixel_x=pixel_y=0, hsync=vsync=1, video_on=0, pixel_tick=0, frame_start=0.
- Defaults, en=1 → pixel_tick every 2 clk; frame_start one clk at start; video_on=1 from first RUN cycle.
- Line scan → video_on falls at pixel_x=640; hsync low for pixel_x 656..751 (192 clk); pixel_x 799→0 with pixel_y 0→1.
- Frame scan → vsync low for pixel_y 490..491 (3200 clk); (799,524)→(0,0) with frame_start pulse; frame period 840000 clk.
- en low at pixel (300,100), high 10 clk later → IDLE values next cycle; restart at (0,0) with frame_start.
- VGA_FRAME_COUNTER_EN, DIV_VALUE=0, small H/V params → frame_count counts 0..255, wraps to 0; holds across en low.
